// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle IEEE-754-style floating-point adder/subtractor,
// parametrised over exponent (EXP_W) and stored fraction (MAN_W) widths.
// Subnormal inputs are treated as signed zero and tiny results flush to zero.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         clock enable; FSM and datapath hold while low
//   start      request, sampled in IDLE with en=1 and not busy
//   op         0 = a+b, 1 = a-b
//   a, b       operands {sign, exponent, fraction}
//   result     registered result, held until the next result is produced
//   done       one-cycle pulse, result valid
//   busy       high from the accepting edge through the done cycle
//   overflow   result overflowed to Inf
//   underflow  nonzero result flushed to zero
//
// Build option: define FPADD_ROUND_RNE_EN for round-to-nearest-even;
// otherwise results are truncated (round toward zero).
module fp_addsub_seq #(
    parameter int unsigned EXP_W = 11,
    parameter int unsigned MAN_W = 52
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 start,
    input  logic                 op,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 done,
    output logic                 busy,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int unsigned W      = 1 + EXP_W + MAN_W;
    localparam int unsigned FW     = MAN_W + 4;    // hidden + fraction + G/R/S
    localparam int unsigned SW     = $clog2(FW);
    localparam int unsigned SH_MAX = MAN_W + 3;
    localparam int unsigned MR_W   = MAN_W + 2;
    localparam int unsigned EW1    = EXP_W + 1;
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

    state_t           state;
    logic [W-1:0]     a_q, b_q;
    logic             sign_q, sub_q, spec_q;
    logic [EXP_W-1:0] exp_q;
    logic [FW-1:0]    ma_q, mb_q;
    logic [FW:0]      m_q;
    logic [W-1:0]     res_q;

    // Unpack, order by magnitude, align the smaller operand, detect specials
    logic             sa, sb, za, zb, ia, ib, na, nb, swap, sl, stk, spec;
    logic [EXP_W-1:0] ea, eb, el, ediff;
    logic [MAN_W-1:0] fa, fb;
    logic [FW-1:0]    ml, ms, ms_sh;
    logic [SW-1:0]    sh;
    logic [W-1:0]     spec_res;

    always_comb begin
        sa = a_q[W-1];  ea = a_q[W-2:MAN_W];  fa = a_q[MAN_W-1:0];
        sb = b_q[W-1];  eb = b_q[W-2:MAN_W];  fb = b_q[MAN_W-1:0];
        za = (ea == '0);
        zb = (eb == '0);
        ia = (ea == EXP_ONES) && (fa == '0);
        ib = (eb == EXP_ONES) && (fb == '0);
        na = (ea == EXP_ONES) && (fa != '0);
        nb = (eb == EXP_ONES) && (fb != '0);
        swap = {eb, fb} > {ea, fa};
        if (swap) begin
            sl = sb;  el = eb;  ediff = eb - ea;
            ml = {1'b1, fb, 3'b000};
            ms = {1'b1, fa, 3'b000};
        end else begin
            sl = sa;  el = ea;  ediff = ea - eb;
            ml = {1'b1, fa, 3'b000};
            ms = {1'b1, fb, 3'b000};
        end
        sh    = (32'(ediff) > SH_MAX) ? SW'(SH_MAX) : SW'(ediff);
        ms_sh = ms >> sh;
        stk   = |(ms & ((FW'(1) << sh) - FW'(1)));
        ms_sh[0] = ms_sh[0] | stk;

        spec     = 1'b1;
        spec_res = QNAN;
        if (na || nb)     spec_res = QNAN;
        else if (ia && ib) spec_res = (sa != sb) ? QNAN : a_q;
        else if (ia)       spec_res = a_q;
        else if (ib)       spec_res = b_q;
        else if (za && zb) spec_res = {sa & sb, {(W-1){1'b0}}};
        else if (zb)       spec_res = a_q;
        else if (za)       spec_res = b_q;
        else               spec = 1'b0;
    end

    // Magnitude add or subtract, with carry bit
    logic [FW:0] sum;
    always_comb begin
        sum = sub_q ? ({1'b0, ma_q} - {1'b0, mb_q}) : ({1'b0, ma_q} + {1'b0, mb_q});
    end

    // Rounding, post-round renormalisation and overflow detection
    logic             inc, round_ovf;
    logic [MR_W-1:0]  mr;
    logic [EXP_W:0]   er;
    logic [MAN_W-1:0] frac;
    logic [W-1:0]     round_res;

    always_comb begin
`ifdef FPADD_ROUND_RNE_EN
        inc = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
`else
        inc = 1'b0;
`endif
        mr   = {1'b0, m_q[FW-1:3]} + MR_W'(inc);
        er   = {1'b0, exp_q} + EW1'(mr[MR_W-1]);
        frac = mr[MR_W-1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
        round_ovf = (er >= {1'b0, EXP_ONES});
        round_res = round_ovf ? {sign_q, EXP_ONES, {MAN_W{1'b0}}}
                              : {sign_q, er[EXP_W-1:0], frac};
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            result    <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            sub_q     <= 1'b0;
            spec_q    <= 1'b0;
            exp_q     <= '0;
            ma_q      <= '0;
            mb_q      <= '0;
            m_q       <= '0;
            res_q     <= '0;
        end else begin
            // done must stay a single pulse even if en drops in the done cycle
            done <= 1'b0;
            if (done) busy <= 1'b0;
            if (en) begin
                unique case (state)
                    IDLE: begin
                        if (start && !busy) begin
                            a_q       <= a;
                            b_q       <= {b[W-1] ^ op, b[W-2:0]};
                            overflow  <= 1'b0;
                            underflow <= 1'b0;
                            busy      <= 1'b1;
                            state     <= ALIGN;
                        end
                    end
                    ALIGN: begin
                        sign_q <= sl;
                        exp_q  <= el;
                        ma_q   <= ml;
                        mb_q   <= ms_sh;
                        sub_q  <= sa ^ sb;
                        spec_q <= spec;
                        res_q  <= spec_res;
                        state  <= ADD;
                    end
                    ADD: begin
                        // Specials resolved in ALIGN leave here, sharing the
                        // short-path latency with exact cancellation.
                        if (spec_q) begin
                            state <= DONE;
                        end else if (sum == '0) begin
                            res_q <= '0;
                            state <= DONE;
                        end else begin
                            m_q   <= sum;
                            state <= NORM;
                        end
                    end
                    NORM: begin
                        if (m_q[FW]) begin
                            m_q   <= {1'b0, m_q[FW:2], m_q[1] | m_q[0]};
                            exp_q <= exp_q + EXP_W'(1);
                            state <= ROUND;
                        end else if (m_q[FW-1]) begin
                            state <= ROUND;
                        end else if (exp_q == EXP_W'(1)) begin
                            m_q       <= '0;
                            exp_q     <= '0;
                            underflow <= 1'b1;
                            state     <= ROUND;
                        end else begin
                            m_q   <= m_q << 1;
                            exp_q <= exp_q - EXP_W'(1);
                        end
                    end
                    ROUND: begin
                        res_q <= round_res;
                        if (round_ovf) overflow <= 1'b1;
                        state <= DONE;
                    end
                    DONE: begin
                        result <= res_q;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/fp_addsub_seq.md
Name: fp_addsub_seq

Overview:
Parametrised, multi-cycle IEEE-754-style floating-point adder/subtractor. It is the next generation of the team's 64-bit addition stage.
- Generalised over exponent and mantissa width, so one block serves half, single and double precision.
- Adds an explicit start/done handshake, a deterministic state machine, proper special-value handling, overflow/underflow flags and compile-time rounding selection.
- Sits between the operand register file and the calculator result mux.

Parameters:
EXP_W, 11, exponent field width in bits (>=4)
MAN_W, 52, stored fraction width in bits (>=4); total word width W = 1+EXP_W+MAN_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
en  input  1  clock enable; when low the FSM and all registers hold
start  input  1  request; sampled only in IDLE with en=1
op  input  1  0 = A+B, 1 = A-B (B sign inverted at capture)
a  input  W  operand A {sign, exponent, fraction}
b  input  W  operand B
result  output  W  registered result, held until the next accepted start
done  output  1  one-cycle pulse: result valid
busy  output  1  high from accepting edge until the done cycle, inclusive
overflow  output  1  sticky for the current result: exponent overflowed to Inf
underflow  output  1  sticky for the current result: nonzero result flushed to zero

Behaviour:
- Reset (async, any state): FSM->IDLE; result=0, done=0, busy=0, overflow=0, underflow=0; the operation in flight is discarded.
- States: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
- IDLE:
  - start=1 & en=1 captures a, b and op, clears both flags, asserts busy, goes to ALIGN.
  - start while busy is ignored.
- ALIGN (1 cycle):
  - Operands are unpacked with the hidden bit set.
  - Exponent field 0 means zero; subnormal inputs are treated as signed zero.
  - Operands are swapped so |A|>=|B|.
  - B is right-shifted by the exponent difference, capped at MAN_W+3, into guard/round/sticky bits; sticky is the OR of all bits shifted out.
  - Special cases resolve here and go straight to DONE:
    - NaN in -> canonical quiet NaN (exp all ones, fraction MSB=1, sign 0).
    - Inf+(-Inf) -> canonical NaN.
    - Inf + any finite -> that Inf.
    - x+0 -> x.
    - 0+0 -> +0, except (-0)+(-0) -> -0.
- ADD (1 cycle):
  - Same effective sign: magnitudes add, MAN_W+4 bits plus carry.
  - Opposite signs: larger minus smaller.
  - Result sign = sign of the larger operand.
  - Exact cancellation -> +0, goes to DONE.
- NORM:
  - Carry out: shift right 1 (folding into sticky), exp+1, leave in 1 cycle.
  - Otherwise, while the hidden bit is 0: shift left 1 and exp-1, one bit per cycle.
  - Leave when the hidden bit is 1, or when exp would drop to 0 -> flush to signed zero, underflow=1.
- ROUND (1 cycle):
  - Applies the rounding mode (see Optional Feature).
  - Mantissa overflow from rounding: shift right 1, exp+1 in the same cycle.
  - Exp reaching all ones -> signed Inf, overflow=1.
- DONE: result registered, done=1 for one cycle, busy drops after this cycle, FSM->IDLE.
- Latency, in en=1 cycles from the accepting edge to the done pulse:
  - Normal path: 5+k, where k = number of left-normalisation shifts (k=0 for no shift or a carry shift).
  - Special-case and exact-cancellation path: 3.
- en=0 stretches latency cycle for cycle; done remains a single pulse.

Optional Feature:
Macro FPADD_ROUND_RNE_EN.
- Defined: round-to-nearest-even using guard/round/sticky; ties round to an even LSB.
- Undefined: truncation (round toward zero); G/R/S are discarded.
- ROUND still takes 1 cycle either way, so latency is identical with or without the macro.

Test Plan (defaults EXP_W=11, MAN_W=52):
1. 1.0+1.0: a=0x3FF0000000000000, b=same, op=0 -> result 0x4000000000000000, done 5 cycles after start, flags 0.
2. 1.5-1.25: a=0x3FF8000000000000, b=0x3FF4000000000000, op=1 -> result 0x3FD0000000000000 (k=2), done at cycle 7; 1.0-1.0 -> 0x0000000000000000, done at cycle 3.
3. Specials:
   - +Inf + -Inf (0x7FF0000000000000, 0xFFF0000000000000) -> 0x7FF8000000000000, done at cycle 3.
   - max+max (0x7FEFFFFFFFFFFFFF twice) -> 0x7FF0000000000000, overflow=1.
4. Rounding: 1.0 + 0x3CA8000000000000 -> 0x3FF0000000000001 with FPADD_ROUND_RNE_EN defined, 0x3FF0000000000000 without it.
5. Control:
   - rst pulsed during NORM -> all outputs 0 immediately, no done pulse.
   - start held high during busy -> exactly one done pulse per accepted start.
   - en low 3 cycles mid-op -> done delayed exactly 3 cycles.
6. Parametrisation, EXP_W=5, MAN_W=10: 0x3C00+0x3C00 -> 0x4000; 0x7BFF+0x7BFF -> 0x7C00 with overflow=1.
